// File: rtl/mmu_dat_ctrl.sv
// Task-based MMU: CPU register file, DAT lookup on bank_out, and a fill engine that rewrites the whole DAT.
// Reads and bank_out are combinational; writes land on the sampling edge; while busy, DAT/FILL writes are dropped.
module mmu_dat_ctrl #(
   parameter int TASK_BITS = 5,
   parameter int BANK_BITS = 8
) (
   input  logic                 e,
   input  logic                 reset,
   input  logic [15:0]          cpu_addr,
   input  logic                 cpu_we,
   input  logic [7:0]           cpu_wdata,
   output logic [7:0]           cpu_rdata,
   output logic                 rd_hit,
   output logic [BANK_BITS-1:0] bank_out,
   output logic                 bank_ext,
   output logic                 busy
);
   localparam int IDX_W = TASK_BITS + 3;
   localparam int N_ENT = 1 << IDX_W;

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   mode_q, mode_d;
   logic                   mmu_en_q, mmu_en_d;
   logic                   crm_en_q, crm_en_d;
   logic [TASK_BITS-1:0]   act_task_q, act_task_d;
   logic [TASK_BITS-1:0]   acc_task_q, acc_task_d;
   logic [BANK_BITS-1:0]   dat_q [N_ENT];

   logic sel_init, sel_act, sel_acc, sel_fill, sel_stat, sel_dat;
   logic wr_ok;
   logic [BANK_BITS-1:0] fill_val;
   logic [BANK_BITS-1:0] dat_act;
   logic [BANK_BITS-1:0] dat_acc;

   assign sel_init = (cpu_addr == 16'hFF90);
   assign sel_act  = (cpu_addr == 16'hFF91);
   assign sel_acc  = (cpu_addr == 16'hFF92);
   assign sel_fill = (cpu_addr == 16'hFF98);
   assign sel_stat = (cpu_addr == 16'hFF99);
   assign sel_dat  = (cpu_addr[15:3] == 13'h1FF4);

   assign wr_ok    = cpu_we & ~reset;
   assign busy     = (state_q == S_FILL);
   assign fill_val = mode_q ? '0 : BANK_BITS'(idx_q);
   assign dat_act  = dat_q[{act_task_q, cpu_addr[15:13]}];
   assign dat_acc  = dat_q[{acc_task_q, cpu_addr[2:0]}];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mode_d     = mode_q;
      mmu_en_d   = mmu_en_q;
      crm_en_d   = crm_en_q;
      act_task_d = act_task_q;
      acc_task_d = acc_task_q;
      if (wr_ok && sel_init) begin
         mmu_en_d = cpu_wdata[6];
         crm_en_d = cpu_wdata[3];
      end
      if (wr_ok && sel_act) act_task_d = cpu_wdata[TASK_BITS-1:0];
      if (wr_ok && sel_acc) acc_task_d = cpu_wdata[TASK_BITS-1:0];
      case (state_q)
         S_IDLE: begin
            if (wr_ok && sel_fill) begin
               state_d = S_FILL;
               idx_d   = '0;
               mode_d  = cpu_wdata[0];
            end
         end
         S_FILL: begin
            idx_d = idx_q + 1'b1;
            // Leave on the last entry so the index never starts a second pass
            if (&idx_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge e) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         mode_q     <= 1'b0;
         mmu_en_q   <= 1'b0;
         crm_en_q   <= 1'b0;
         act_task_q <= '0;
         acc_task_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mode_q     <= mode_d;
         mmu_en_q   <= mmu_en_d;
         crm_en_q   <= crm_en_d;
         act_task_q <= act_task_d;
         acc_task_q <= acc_task_d;
      end
   end

   // DAT is never cleared; reset only suppresses the write on that edge
   always_ff @(posedge e) begin
      if (!reset) begin
         if (busy)
            dat_q[idx_q] <= fill_val;
         else if (cpu_we && sel_dat)
            dat_q[{acc_task_q, cpu_addr[2:0]}] <= BANK_BITS'(cpu_wdata);
      end
   end

   always_comb begin
      if (crm_en_q && cpu_addr[15:8] == 8'hFE)
         bank_out = '1;
      else if (mmu_en_q && !busy && cpu_addr[15:8] != 8'hFF)
         bank_out = dat_act;
      else
         bank_out = BANK_BITS'(cpu_addr[15:13]);
   end

   assign bank_ext = |bank_out[BANK_BITS-1:3];

   always_comb begin
      cpu_rdata = 8'h00;
      rd_hit    = 1'b0;
      if (sel_init) begin
         rd_hit    = 1'b1;
         cpu_rdata = {1'b0, mmu_en_q, 2'b00, crm_en_q, 3'b000};
      end else if (sel_act) begin
         rd_hit    = 1'b1;
         cpu_rdata = 8'(act_task_q);
      end else if (sel_acc) begin
         rd_hit    = 1'b1;
         cpu_rdata = 8'(acc_task_q);
      end else if (sel_fill) begin
         rd_hit    = 1'b1;
         cpu_rdata = {7'b0, mode_q};
      end else if (sel_stat) begin
         rd_hit    = 1'b1;
         cpu_rdata = {7'b0, busy};
      end else if (sel_dat) begin
         rd_hit    = 1'b1;
         cpu_rdata = busy ? 8'h00 : 8'(dat_acc);
      end
   end
endmodule

// File: tb/tb_mmu_dat_ctrl.sv
// Directed bench: default-parameter instance plus a TASK_BITS=2/BANK_BITS=4 instance sharing the CPU bus.
module tb_mmu_dat_ctrl;
   logic        e = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;

   logic [7:0]  rdata_b, rdata_s;
   logic        rd_hit_b, rd_hit_s;
   logic [7:0]  bank_out_b;
   logic [3:0]  bank_out_s;
   logic        bank_ext_b, bank_ext_s;
   logic        busy_b, busy_s;

   int n_chk  = 0;
   int n_pass = 0;
   int cnt_b  = 0;
   int cnt_s  = 0;

   mmu_dat_ctrl u_big (
      .e(e), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdata(rdata_b), .rd_hit(rd_hit_b), .bank_out(bank_out_b), .bank_ext(bank_ext_b),
      .busy(busy_b)
   );

   mmu_dat_ctrl #(.TASK_BITS(2), .BANK_BITS(4)) u_small (
      .e(e), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdata(rdata_s), .rd_hit(rd_hit_s), .bank_out(bank_out_s), .bank_ext(bank_ext_s),
      .busy(busy_s)
   );

   always #5 e = ~e;

   always @(posedge e) begin
      if (busy_b) cnt_b++;
      if (busy_s) cnt_s++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge e);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_we    = 1'b1;
      @(negedge e);
      cpu_we    = 1'b0;
   endtask

   task automatic setaddr(input logic [15:0] a);
      @(negedge e);
      cpu_addr = a;
      #1;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      setaddr(a);
      d = rdata_b;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_b || busy_s) && n < 2000) begin
         @(negedge e);
         n++;
      end
      chk("fill_done", {30'b0, busy_b, busy_s}, 32'h0);
   endtask

   initial begin
      logic [7:0] d;
      int b0, s0;
      reset = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      repeat (3) @(negedge e);
      reset = 1'b0;

      rd(16'hFF90, d); chk("rst_init", d, 8'h00);
      rd(16'hFF91, d); chk("rst_act", d, 8'h00);
      rd(16'hFF92, d); chk("rst_acc", d, 8'h00);
      rd(16'hFF98, d); chk("rst_mode", d, 8'h00);
      rd(16'hFF99, d); chk("rst_status", d, 8'h00);
      setaddr(16'hE000);
      chk("rst_bank", bank_out_b, 8'h07);
      chk("rst_ext", bank_ext_b, 1'b0);
      chk("rst_busy", {busy_b, busy_s}, 2'b00);
      setaddr(16'hFF93);
      chk("miss_hit", rd_hit_b, 1'b0);
      chk("miss_rdata", rdata_b, 8'h00);
      setaddr(16'hFFA7);
      chk("dat_hit", rd_hit_b, 1'b1);

      // Mode-0 fill with ignored writes issued while both instances are busy
      b0 = cnt_b; s0 = cnt_s;
      wr(16'hFF98, 8'h00);
      repeat (3) @(negedge e);
      wr(16'hFFA2, 8'h40);
      wr(16'hFF98, 8'h01);
      wr(16'hFF92, 8'h03);
      repeat (60) @(negedge e);
      rd(16'hFFA5, d); chk("busy_dat_rd", d, 8'h00);
      rd(16'hFF99, d); chk("busy_status", d, 8'h01);
      rd(16'hFF92, d); chk("busy_acc_wr", d, 8'h03);
      wait_idle();
      chk("busy_cycles", cnt_b - b0, 256);
      chk("busy_cycles_small", cnt_s - s0, 32);
      rd(16'hFF98, d); chk("mode_after", d, 8'h00);
      rd(16'hFFA5, d); chk("dat_29", d, 8'h1D);
      wr(16'hFF92, 8'h00);
      rd(16'hFFA2, d); chk("dat_2_kept", d, 8'h02);
      wr(16'hFF92, 8'h02);
      setaddr(16'hFFA5);
      chk("small_dat_21", rdata_s, 8'h05);

      wr(16'hFF90, 8'h40);
      wr(16'hFF91, 8'h03);
      setaddr(16'hA000);
      chk("mmu_bank", bank_out_b, 8'h1D);
      chk("mmu_ext", bank_ext_b, 1'b1);
      setaddr(16'h0000);
      chk("mmu_bank_0", bank_out_b, 8'h18);
      setaddr(16'hFF10);
      chk("mmu_ffpage", bank_out_b, 8'h07);

      wr(16'hFF90, 8'hFF);
      rd(16'hFF90, d); chk("init_mask", d, 8'h48);
      setaddr(16'hFE10);
      chk("crm_bank", bank_out_b, 8'hFF);
      chk("crm_ext", bank_ext_b, 1'b1);
      setaddr(16'hFF10);
      chk("crm_ffpage", bank_out_b, 8'h07);
      chk("crm_ffpage_ext", bank_ext_b, 1'b0);

      // Mode-1 fill aborted by reset while entry 10 is due
      wr(16'hFF98, 8'h01);
      repeat (10) @(negedge e);
      reset = 1'b1;
      @(negedge e);
      reset = 1'b0;
      #1;
      chk("abort_busy", busy_b, 1'b0);
      rd(16'hFF98, d); chk("abort_mode", d, 8'h00);
      rd(16'hFF90, d); chk("abort_init", d, 8'h00);
      wr(16'hFF92, 8'h01);
      rd(16'hFFA1, d); chk("abort_ent9", d, 8'h00);
      rd(16'hFFA2, d); chk("abort_ent10", d, 8'h0A);
      rd(16'hFFA3, d); chk("abort_ent11", d, 8'h0B);
      wr(16'hFF92, 8'h00);
      rd(16'hFFA5, d); chk("abort_ent5", d, 8'h00);

      @(negedge e);
      cpu_addr = 16'hFFA3; cpu_wdata = 8'h77; cpu_we = 1'b1; reset = 1'b1;
      @(negedge e);
      cpu_we = 1'b0; reset = 1'b0;
      rd(16'hFFA3, d); chk("rst_wr_drop", d, 8'h00);
      wr(16'hFFA3, 8'h77);
      rd(16'hFFA3, d); chk("idle_dat_wr", d, 8'h77);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
